// File: rtl/rv32is_dmem.sv
// rv32is_dmem: single-clock data memory for the rv32is core.
// Byte/half/word loads and stores, one-cycle registered read latency,
// plus a memory-mapped watch register at WATCH_ADDR.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned accesses set sticky misalign, stores are
//                dropped, loads return zero.
//   undefined -> misaligned addresses are aligned down, misalign is 0.
module rv32is_dmem #(
  parameter int          WORDS_LOG2 = 10,
  parameter logic [31:0] WATCH_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemdatain,
  input  logic [2:0]  dmemop,
  input  logic        dmemwe,
  input  logic        dmemre,
  output logic [31:0] dmemdataout,
  output logic        dmemvalid,
  output logic [31:0] watchdata,
  output logic [15:0] watchcount,
  output logic        misalign
);

  localparam int DEPTH = 1 << WORDS_LOG2;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_dout;
  logic        r_valid;
  logic [31:0] r_watch;
  logic [15:0] r_wcnt;
  logic        r_mis;

  logic [WORDS_LOG2-1:0] w_idx;
  logic        w_watch;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_signed;
  logic        w_bad_align;
  logic        w_mis;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_old;
  logic [31:0] w_merged;
  logic [7:0]  w_bsel;
  logic [15:0] w_hsel;
  logic [31:0] w_ld;

  assign w_idx     = dmemaddr[WORDS_LOG2+1:2];
  assign w_watch   = (dmemaddr[31:2] == WATCH_ADDR[31:2]);
  // Only 00/01 in the low bits select byte/half; everything else is a word.
  assign w_is_byte = (dmemop[1:0] == 2'b00);
  assign w_is_half = (dmemop[1:0] == 2'b01);
  assign w_signed  = ~dmemop[2];
  assign w_bad_align = (w_is_half & dmemaddr[0]) |
                       (~w_is_byte & ~w_is_half & (dmemaddr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = w_bad_align;
`else
  assign w_mis = 1'b0;
`endif

  // Decode aligned lane, byte enables and replicated store data
  always_comb begin
    w_lane  = 2'b00;
    w_be    = 4'b1111;
    w_wdata = dmemdatain;
    if (w_is_byte) begin
      w_lane  = dmemaddr[1:0];
      w_be    = 4'b0001 << dmemaddr[1:0];
      w_wdata = {4{dmemdatain[7:0]}};
    end else if (w_is_half) begin
      w_lane  = {dmemaddr[1], 1'b0};
      w_be    = dmemaddr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{dmemdatain[15:0]}};
    end
  end

  // Pre-write word seen by a load; the watch register shadows RAM
  assign w_old = w_watch ? r_watch : r_mem[w_idx];

  // Byte-lane merge of store data into the current watch value
  always_comb begin
    w_merged = r_watch;
    for (int b = 0; b < 4; b++)
      if (w_be[b]) w_merged[8*b +: 8] = w_wdata[8*b +: 8];
  end

  // Load extraction and sign/zero extension
  always_comb begin
    case (w_lane)
      2'd0:    w_bsel = w_old[7:0];
      2'd1:    w_bsel = w_old[15:8];
      2'd2:    w_bsel = w_old[23:16];
      default: w_bsel = w_old[31:24];
    endcase
    w_hsel = w_lane[1] ? w_old[31:16] : w_old[15:0];
    if (w_is_byte)      w_ld = {{24{w_signed & w_bsel[7]}}, w_bsel};
    else if (w_is_half) w_ld = {{16{w_signed & w_hsel[15]}}, w_hsel};
    else                w_ld = w_old;
    if (w_mis) w_ld = 32'h0;
  end

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (dmemwe && !w_watch && !w_mis)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
  end

  // Load result register and valid pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dout  <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= dmemre;
      if (dmemre) r_dout <= w_ld;
    end
  end

  // Watch register, store counter and sticky misalign flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_watch <= 32'h0;
      r_wcnt  <= 16'h0;
      r_mis   <= 1'b0;
    end else begin
      if (dmemwe && w_watch && !w_mis) begin
        r_watch <= w_merged;
        r_wcnt  <= r_wcnt + 16'd1;
      end
      if ((dmemwe || dmemre) && w_mis) r_mis <= 1'b1;
    end
  end

  assign dmemdataout = r_dout;
  assign dmemvalid   = r_valid;
  assign watchdata   = r_watch;
  assign watchcount  = r_wcnt;
  assign misalign    = r_mis;

endmodule
